// File: rtl/irrigation_pkg.sv
// -----------------------------------------------------------------------------
// irrigation_pkg
// Shared types and helpers for the irrigation sequencer.
//   state_e        : FSM state codes, also exported on the debug 'state' port
//   sensor_bad()   : tank probe consistency check (a higher probe wet while a
//                    lower one is dry means a broken or stuck sensor)
// -----------------------------------------------------------------------------
package irrigation_pkg;

    localparam int unsigned TW_DEFAULT           = 8;
    localparam int unsigned MAX_ON_TICKS_DEFAULT = 60;
    localparam int unsigned SETTLE_TICKS_DEFAULT = 30;
    localparam int unsigned REFILL_TICKS_DEFAULT = 120;
    localparam int unsigned ALARM_HOLD_DEFAULT   = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SPRINKLE = 3'd1,
        ST_DRIP     = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_FAULT    = 3'd4
    } state_e;

    // Probes are stacked low < mid < high; water cannot reach a higher probe
    // while a lower one reads dry.
    function automatic logic sensor_bad(input logic low, input logic mid, input logic high);
        return (mid & ~low) | (high & ~mid);
    endfunction

endpackage

// File: rtl/irrigation_sequencer_tick_timer.sv
// -----------------------------------------------------------------------------
// tick_timer
// Saturating tick counter used for every timed interval of the sequencer.
//   clk, rst_n  : clock, synchronous active-low reset
//   clear_i     : force count to zero (wins over counting)
//   enable_i    : allow counting
//   tick_i      : time-base strobe; one increment per clk with tick_i high
//   limit_i     : saturation value
//   count_o     : current count (never exceeds limit_i)
//   done_o      : count_o == limit_i
// -----------------------------------------------------------------------------
module tick_timer #(
    parameter int unsigned TW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          enable_i,
    input  logic          tick_i,
    input  logic [TW-1:0] limit_i,
    output logic [TW-1:0] count_o,
    output logic          done_o
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && tick_i && (count_q != limit_i)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign done_o  = (count_q == limit_i);

endmodule

// File: rtl/irrigation_sequencer.sv
// -----------------------------------------------------------------------------
// irrigation_sequencer
// Clocked controller for the drip/sprinkler irrigation plant: sensor
// validation with a latched alarm, timed irrigation cycles, post-cycle settle
// interval, and a tank refill path guarded by a watchdog.
//   clk, rst_n               : clock, synchronous active-low reset
//   tick                     : time-base strobe; all intervals count ticks
//   low/mid/high_water_level : tank probes (1 = wet)
//   earth_humidity           : soil humid, no irrigation needed
//   air_humidity             : air humid
//   low_temperature          : temperature low
//   water_supply_valvule     : tank inlet valve open
//   splinker_bomb            : sprinkler pump on
//   dripper_valvule          : dripper valve open
//   alarm                    : latched fault indication
//   state                    : current FSM state code (debug)
// All outputs are registered.
// -----------------------------------------------------------------------------
module irrigation_sequencer
    import irrigation_pkg::*;
#(
    parameter int unsigned TW           = TW_DEFAULT,
    parameter int unsigned MAX_ON_TICKS = MAX_ON_TICKS_DEFAULT,
    parameter int unsigned SETTLE_TICKS = SETTLE_TICKS_DEFAULT,
    parameter int unsigned REFILL_TICKS = REFILL_TICKS_DEFAULT,
    parameter int unsigned ALARM_HOLD   = ALARM_HOLD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       low_water_level,
    input  logic       mid_water_level,
    input  logic       high_water_level,
    input  logic       earth_humidity,
    input  logic       air_humidity,
    input  logic       low_temperature,
    output logic       water_supply_valvule,
    output logic       splinker_bomb,
    output logic       dripper_valvule,
    output logic       alarm,
    output logic [2:0] state
);

    // Every limit has to fit the counter width, otherwise a timer never
    // reaches its limit.
    if ((MAX_ON_TICKS >= (64'd1 << TW)) || (SETTLE_TICKS >= (64'd1 << TW)) ||
        (REFILL_TICKS >= (64'd1 << TW)) || (ALARM_HOLD >= (64'd1 << TW))) begin : g_param_check
        $error("irrigation_sequencer: tick limits must be below 2**TW");
    end

    state_e state_q, state_d;
    logic   alarm_q, alarm_d;
    logic   valve_q, valve_d;
    logic   spr_q,   spr_d;
    logic   drip_q,  drip_d;

    logic   bad;
    logic   in_cycle;
    logic   cycle_exit;
    logic   mode_spr;

    logic [TW-1:0] on_cnt, settle_cnt, refill_cnt, good_cnt;
    logic          on_done, settle_done, refill_done, good_done;

    assign bad      = sensor_bad(low_water_level, mid_water_level, high_water_level);
    assign in_cycle = (state_q == ST_SPRINKLE) || (state_q == ST_DRIP);
    assign mode_spr = ~air_humidity & ~low_temperature & mid_water_level;

    // Any exit condition wins over the tick in the same clk: the on timer is
    // cleared instead of incremented.
    assign cycle_exit = earth_humidity | ~low_water_level | on_done;

    // ---------------------------------------------------------------- timers
    tick_timer #(.TW(TW)) u_on_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (~in_cycle | cycle_exit),
        .enable_i (in_cycle),
        .tick_i   (tick),
        .limit_i  (TW'(MAX_ON_TICKS)),
        .count_o  (on_cnt),
        .done_o   (on_done)
    );

    tick_timer #(.TW(TW)) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (state_q != ST_SETTLE),
        .enable_i (1'b1),
        .tick_i   (tick),
        .limit_i  (TW'(SETTLE_TICKS)),
        .count_o  (settle_cnt),
        .done_o   (settle_done)
    );

    // Refill watchdog: runs only while the inlet valve is open.
    tick_timer #(.TW(TW)) u_refill_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (~valve_q),
        .enable_i (1'b1),
        .tick_i   (tick),
        .limit_i  (TW'(REFILL_TICKS)),
        .count_o  (refill_cnt),
        .done_o   (refill_done)
    );

    // Consecutive good-sensor ticks while alarmed; any bad reading restarts it.
    tick_timer #(.TW(TW)) u_good_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (~alarm_q | bad),
        .enable_i (1'b1),
        .tick_i   (tick),
        .limit_i  (TW'(ALARM_HOLD)),
        .count_o  (good_cnt),
        .done_o   (good_done)
    );

    // Counts are only consumed through the done flags.
    logic unused_cnt;
    assign unused_cnt = ^{on_cnt, settle_cnt, refill_cnt, good_cnt};

    // ------------------------------------------------------ alarm and refill
    always_comb begin
        alarm_d = alarm_q;
        if (bad || refill_done) begin
            alarm_d = 1'b1;
        end else if (alarm_q && good_done) begin
            alarm_d = 1'b0;
        end
        // Valve follows the next alarm value so it closes on the same clk
        // the alarm latches.
        valve_d = ~alarm_d & ~high_water_level;
    end

    // ------------------------------------------------------------------ FSM
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (~alarm_q & ~earth_humidity & low_water_level) begin
                    state_d = mode_spr ? ST_SPRINKLE : ST_DRIP;
                end
            end
            ST_SPRINKLE, ST_DRIP: begin
                // Mode is carried by the state itself, so it cannot change
                // mid-cycle.
                if (cycle_exit) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (!alarm_d) begin
                    state_d = ST_SETTLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Alarm overrides every other transition.
        if (alarm_d) begin
            state_d = ST_FAULT;
        end
        spr_d  = (state_d == ST_SPRINKLE);
        drip_d = (state_d == ST_DRIP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            alarm_q <= 1'b0;
            valve_q <= 1'b0;
            spr_q   <= 1'b0;
            drip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            alarm_q <= alarm_d;
            valve_q <= valve_d;
            spr_q   <= spr_d;
            drip_q  <= drip_d;
        end
    end

    assign water_supply_valvule = valve_q;
    assign splinker_bomb        = spr_q;
    assign dripper_valvule      = drip_q;
    assign alarm                = alarm_q;
    assign state                = state_q;

endmodule
